instr_adder_sweep: RTL and testbench
====================================

# instr_adder_sweep

Operand sequencer and measurement controller directly upstream of the wrapped instrumented Brent-Kung adder. On a start command it drives a sequence of operand pairs into the adder, runs the adder's ring-oscillator measurement for a programmed window per point, and collects ring count plus sum in a small result FIFO. The FIFO is read out over the logic-analyser bus. This removes the need for firmware to poke every operand and window by hand.

## Interface
Parameters:
- WIDTH, 32, operand/sum width
- CNT_W, 32, ring-count and window width
- DEPTH, 4, result FIFO entries (power of two)
- SETTLE, 2, cycles operands are held before ring_en rises

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle start pulse; sampled only in IDLE
- abort  in  1  synchronous abort, any state
- cfg_a  in  WIDTH  first a operand
- cfg_b  in  WIDTH  b operand, constant for a sweep
- cfg_mode  in  2  0 fixed, 1 a+=1, 2 a rotate-left 1, 3 reserved (= fixed)
- cfg_points  in  8  number of points
- cfg_window  in  CNT_W  ring_en high time in cycles (0 treated as 1)
- a_out  out  WIDTH  operand a to adder
- b_out  out  WIDTH  operand b to adder
- ring_en  out  1  enables the adder ring oscillator
- count_clr  out  1  clears the adder's ring counter
- ring_count  in  CNT_W  adder ring counter value
- sum_in  in  WIDTH  adder sum output
- res_valid  out  1  FIFO not empty
- res_ready  in  1  pop on res_valid & res_ready
- res_count  out  CNT_W  head ring count
- res_sum  out  WIDTH  head sum
- busy  out  1  FSM not IDLE
- done  out  1  one-cycle pulse at sweep end or abort

## Operation
- Reset: all outputs 0; FIFO empty; FSM IDLE.
- Start and configuration:
  - start in IDLE latches all cfg_* inputs and sets point index = 0.
  - If cfg_points = 0, go straight to FINISH.
  - start while busy is ignored.
- IDLE -> LOAD: drive a_out/b_out with the current operands; count_clr = 1 for exactly this cycle.
- LOAD -> SETTLE: hold SETTLE cycles.
- SETTLE -> RUN: ring_en = 1 for max(cfg_window, 1) cycles.
- RUN -> CAPTURE:
  - ring_en = 0.
  - Push {ring_count, sum_in} when the FIFO is not full.
  - When full, stay in CAPTURE with operands held until a pop frees space. Results are never dropped.
- CAPTURE -> NEXT: index += 1 and the operand updates per mode.
  - Mode 1: a wraps modulo 2^WIDTH.
  - Mode 2: MSB goes to LSB.
  - If index == latched cfg_points, go to FINISH; else go to LOAD.
- FINISH: done = 1 for one cycle -> IDLE.
- Operands outside LOAD..CAPTURE: a_out/b_out hold their last values; ring_en is low.
- abort in any non-IDLE state:
  - Next cycle: ring_en = 0, done pulses, FSM returns to IDLE.
  - FIFO contents are kept. A partial point is not pushed.
- abort takes priority over start and all transitions.
- FIFO:
  - Simultaneous push and pop is allowed when full or empty.
  - A pop when empty is ignored.

## Timing
- start at cycle 0: a_out valid and count_clr high in cycle 1; ring_en high cycles 1+SETTLE+1 through 1+SETTLE+W, where W = max(cfg_window, 1).
- Capture samples ring_count one cycle after ring_en falls. The adder counter is registered, so the final count is visible then.
- Point period with a non-full FIFO: 3 + SETTLE + W cycles.
- res_valid rises the cycle after push. FIFO read latency is 0 (head registered, show-ahead).
- done rises one cycle after the last CAPTURE→NEXT, or one cycle after abort.
- Reset mid-sweep: the next edge returns to reset values; the FIFO is emptied.

## Structure
- Shared package instr_adder_pkg holds:
  - the state enum (IDLE, LOAD, SETTLE, RUN, CAPTURE, NEXT, FINISH)
  - the mode constants (MODE_FIXED, MODE_INC, MODE_ROT)
  - the default WIDTH/CNT_W
- One sub-module: instr_result_fifo, a parametric show-ahead FIFO (data width CNT_W+WIDTH, DEPTH) with full/empty flags.

## Test plan
- Basic point: cfg_a=5, cfg_b=3, mode 0, points=1, window=4, model count = cycles enabled.
  - ring_en high exactly 4 cycles.
  - One FIFO entry with sum 8 and count 4.
  - done pulses once.
- Increment sweep: cfg_a=0xFFFFFFFE, cfg_b=1, mode 1, points=3.
  - Sums 0xFFFFFFFF, 0x00000000, 0x00000001; a wraps.
- Rotate mode: cfg_a=0x80000000, mode 2, points=2.
  - Second point a_out=0x00000001.
- Backpressure: points=6, DEPTH=4, res_ready=0.
  - FSM stalls in CAPTURE after 4 entries with ring_en low.
  - With res_ready=1: all 6 entries arrive in order and none is lost.
- Edge cases:
  - points=0 → done pulses 1 cycle after start, no pushes.
  - window=0 → behaves as 1.
  - start during busy → ignored.
- Abort and reset:
  - abort during RUN of point 2 → ring_en low next cycle, done pulses, FIFO holds only point 1.
  - wb_rst_n=0 mid-sweep → all outputs 0 and FIFO empty the next cycle.

Source files
------------

// File: rtl/instr_adder_pkg.sv
// Shared definitions for the instrumented-adder operand sweep controller.
package instr_adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 32;

    localparam logic [1:0] MODE_FIXED = 2'd0;
    localparam logic [1:0] MODE_INC   = 2'd1;
    localparam logic [1:0] MODE_ROT   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_RUN     = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_NEXT    = 3'd5,
        ST_FINISH  = 3'd6
    } state_e;

endpackage

// File: rtl/instr_result_fifo.sv
// Show-ahead result FIFO. The head is read straight from the register array,
// so data is visible the cycle after a push. An empty FIFO presents zero.
// DEPTH must be a power of two, at least 2.
module instr_result_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_q, wr_d;
    logic [AW:0]   rd_q, rd_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot being written when full.
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    // Pointer next-state.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array, no reset needed since empty masks the head.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/instr_adder_sweep.sv
// Operand sweep and ring-oscillator measurement controller for the
// instrumented Brent-Kung adder. Results {ring_count, sum} go to a FIFO.
//
// state      | meaning
// IDLE       | waiting for start
// LOAD       | operands driven, ring counter cleared
// SETTLE     | operands held SETTLE cycles
// RUN        | ring_en high for the measurement window
// CAPTURE    | push {ring_count, sum}; stalls while FIFO full
// NEXT       | decide next point or finish
// FINISH     | done pulse
module instr_adder_sweep
    import instr_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] cfg_a,
    input  logic [WIDTH-1:0] cfg_b,
    input  logic [1:0]       cfg_mode,
    input  logic [7:0]       cfg_points,
    input  logic [CNT_W-1:0] cfg_window,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             ring_en,
    output logic             count_clr,
    input  logic [CNT_W-1:0] ring_count,
    input  logic [WIDTH-1:0] sum_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count,
    output logic [WIDTH-1:0] res_sum,
    output logic             busy,
    output logic             done
);

    localparam int DW        = CNT_W + WIDTH;
    localparam int SETTLE_M1 = (SETTLE > 0) ? SETTLE - 1 : 0;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_cur_q, a_cur_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       mode_q, mode_d;
    logic [7:0]       points_q, points_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic [7:0]       idx_q, idx_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [WIDTH-1:0] a_out_q, a_out_d;
    logic [WIDTH-1:0] b_out_q, b_out_d;

    logic [CNT_W-1:0] settle_ld;
    logic [CNT_W-1:0] win_ld;
    logic [WIDTH-1:0] a_step;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [DW-1:0]    fifo_dout;

    assign settle_ld = CNT_W'(SETTLE_M1);
    // A zero window still runs the ring for one cycle.
    assign win_ld    = (win_q == '0) ? '0 : win_q - CNT_W'(1);
    assign pop       = res_valid && res_ready;

    // Operand update for the following point.
    always_comb begin
        case (mode_q)
            MODE_INC: a_step = a_cur_q + WIDTH'(1);
            MODE_ROT: a_step = {a_cur_q[WIDTH-2:0], a_cur_q[WIDTH-1]};
            default:  a_step = a_cur_q;
        endcase
    end

    // Sequencer next-state, timer and operand bookkeeping.
    always_comb begin
        state_d  = state_q;
        a_cur_d  = a_cur_q;
        b_d      = b_q;
        mode_d   = mode_q;
        points_d = points_q;
        win_d    = win_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        a_out_d  = a_out_q;
        b_out_d  = b_out_q;
        push     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    a_cur_d  = cfg_a;
                    b_d      = cfg_b;
                    mode_d   = cfg_mode;
                    points_d = cfg_points;
                    win_d    = cfg_window;
                    idx_d    = '0;
                    state_d  = (cfg_points == 8'd0) ? ST_FINISH : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (SETTLE == 0) begin
                    state_d = ST_RUN;
                    timer_d = win_ld;
                end else begin
                    state_d = ST_SETTLE;
                    timer_d = settle_ld;
                end
            end
            ST_SETTLE: begin
                if (timer_q == '0) begin
                    state_d = ST_RUN;
                    timer_d = win_ld;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (timer_q == '0) state_d = ST_CAPTURE;
                else               timer_d = timer_q - CNT_W'(1);
            end
            ST_CAPTURE: begin
                if (!fifo_full || pop) begin
                    push    = 1'b1;
                    idx_d   = idx_q + 8'd1;
                    a_cur_d = a_step;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                state_d = (idx_q == points_q) ? ST_FINISH : ST_LOAD;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Abort wins over everything; a partial point is discarded.
        if (abort && state_q != ST_IDLE) begin
            state_d = (state_q == ST_FINISH) ? ST_IDLE : ST_FINISH;
            push    = 1'b0;
            a_cur_d = a_cur_q;
            idx_d   = idx_q;
            timer_d = timer_q;
        end

        // Operands only change as a point is loaded, so they hold elsewhere.
        if (state_d == ST_LOAD) begin
            a_out_d = a_cur_d;
            b_out_d = b_d;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state_q  <= ST_IDLE;
            a_cur_q  <= '0;
            b_q      <= '0;
            mode_q   <= MODE_FIXED;
            points_q <= '0;
            win_q    <= '0;
            idx_q    <= '0;
            timer_q  <= '0;
            a_out_q  <= '0;
            b_out_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_cur_q  <= a_cur_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            points_q <= points_d;
            win_q    <= win_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            a_out_q  <= a_out_d;
            b_out_q  <= b_out_d;
        end
    end

    assign a_out     = a_out_q;
    assign b_out     = b_out_q;
    assign ring_en   = (state_q == ST_RUN);
    assign count_clr = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FINISH);

    instr_result_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_n_i (wb_rst_n),
        .push_i  (push),
        .din_i   ({ring_count, sum_in}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign res_valid = !fifo_empty;
    assign res_count = fifo_dout[DW-1:WIDTH];
    assign res_sum   = fifo_dout[WIDTH-1:0];

endmodule

// File: tb/tb_instr_adder_sweep.sv
// Directed bench for instr_adder_sweep with a behavioural adder stub:
// sum is a+b, ring counter clears on count_clr and counts ring_en cycles.
module tb_instr_adder_sweep;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n;
    logic        start, abort;
    logic [31:0] cfg_a, cfg_b;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_points;
    logic [31:0] cfg_window;
    logic [31:0] a_out, b_out;
    logic        ring_en, count_clr;
    logic [31:0] ring_count;
    logic [31:0] sum_in;
    logic        res_valid, res_ready;
    logic [31:0] res_count, res_sum;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    logic [31:0] ring_cnt_q = '0;
    always @(posedge wb_clk_i) begin
        if (count_clr)    ring_cnt_q <= '0;
        else if (ring_en) ring_cnt_q <= ring_cnt_q + 32'd1;
    end
    assign ring_count = ring_cnt_q;
    assign sum_in     = a_out + b_out;

    instr_adder_sweep #(
        .WIDTH (32), .CNT_W (32), .DEPTH (4), .SETTLE (2)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n   (wb_rst_n),
        .start      (start),
        .abort      (abort),
        .cfg_a      (cfg_a),
        .cfg_b      (cfg_b),
        .cfg_mode   (cfg_mode),
        .cfg_points (cfg_points),
        .cfg_window (cfg_window),
        .a_out      (a_out),
        .b_out      (b_out),
        .ring_en    (ring_en),
        .count_clr  (count_clr),
        .ring_count (ring_count),
        .sum_in     (sum_in),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_count  (res_count),
        .res_sum    (res_sum),
        .busy       (busy),
        .done       (done)
    );

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic start_sweep(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                               input logic [7:0] p, input logic [31:0] w);
        cfg_a = a; cfg_b = b; cfg_mode = m; cfg_points = p; cfg_window = w;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called in cycle 1 of a sweep; runs until busy drops.
    task automatic watch(input int max_c, output int ring_hi, output int ring_first,
                         output int done_n, output int done_cyc);
        int end_c;
        ring_hi = 0; ring_first = -1; done_n = 0; done_cyc = -1; end_c = -1;
        for (int c = 1; c <= max_c; c++) begin
            if (ring_en) begin
                ring_hi++;
                if (ring_first < 0) ring_first = c;
            end
            if (done) begin
                done_n++;
                done_cyc = c;
            end
            if (!busy) begin
                end_c = c;
                break;
            end
            tick();
        end
        check("sweep_ends", 64'(end_c >= 0), 64'd1);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp_sum, input logic [31:0] exp_cnt);
        int n = 0;
        while (!res_valid && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 64'(res_valid), 64'd1);
        check({tag, "_sum"},   64'(res_sum),   64'(exp_sum));
        check({tag, "_count"}, 64'(res_count), 64'(exp_cnt));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    int hi, first, dn, dcyc;

    initial begin
        wb_rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
        cfg_a = '0; cfg_b = '0; cfg_mode = '0; cfg_points = '0; cfg_window = '0;
        tick(); tick();
        check("rst_a_out",     64'(a_out),     64'd0);
        check("rst_ring_en",   64'(ring_en),   64'd0);
        check("rst_count_clr", 64'(count_clr), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_done",      64'(done),      64'd0);
        wb_rst_n = 1'b1;
        tick();

        // Basic point: 5+3, window 4.
        start_sweep(32'd5, 32'd3, 2'd0, 8'd1, 32'd4);
        check("basic_count_clr", 64'(count_clr), 64'd1);
        check("basic_a_out",     64'(a_out),     64'd5);
        check("basic_b_out",     64'(b_out),     64'd3);
        watch(40, hi, first, dn, dcyc);
        check("basic_ring_cycles", 64'(hi),    64'd4);
        check("basic_ring_first",  64'(first), 64'd4);
        check("basic_done_pulses", 64'(dn),    64'd1);
        check("basic_done_cycle",  64'(dcyc),  64'd10);
        pop_check("basic", 32'd8, 32'd4);
        check("basic_drained", 64'(res_valid), 64'd0);

        // Increment sweep with wrap.
        start_sweep(32'hFFFF_FFFE, 32'd1, 2'd1, 8'd3, 32'd2);
        watch(80, hi, first, dn, dcyc);
        check("inc_ring_cycles", 64'(hi), 64'd6);
        pop_check("inc0", 32'hFFFF_FFFF, 32'd2);
        pop_check("inc1", 32'h0000_0000, 32'd2);
        pop_check("inc2", 32'h0000_0001, 32'd2);

        // Rotate mode.
        start_sweep(32'h8000_0000, 32'd0, 2'd2, 8'd2, 32'd1);
        watch(60, hi, first, dn, dcyc);
        check("rot_a_out_held", 64'(a_out), 64'h1);
        pop_check("rot0", 32'h8000_0000, 32'd1);
        pop_check("rot1", 32'h0000_0001, 32'd1);

        // Backpressure: 6 points into a 4-deep FIFO.
        start_sweep(32'd10, 32'd0, 2'd1, 8'd6, 32'd1);
        for (int i = 0; i < 60; i++) tick();
        check("bp_stalled_busy",    64'(busy),      64'd1);
        check("bp_stalled_ring_en", 64'(ring_en),   64'd0);
        check("bp_stalled_clr",     64'(count_clr), 64'd0);
        for (int i = 0; i < 6; i++) pop_check($sformatf("bp%0d", i), 32'd10 + 32'(i), 32'd1);
        for (int i = 0; i < 30 && busy; i++) tick();
        check("bp_idle",  64'(busy),      64'd0);
        check("bp_empty", 64'(res_valid), 64'd0);

        // points = 0.
        start_sweep(32'd1, 32'd1, 2'd0, 8'd0, 32'd3);
        check("p0_done",  64'(done),      64'd1);
        check("p0_valid", 64'(res_valid), 64'd0);
        tick();
        check("p0_done_low", 64'(done), 64'd0);
        check("p0_idle",     64'(busy), 64'd0);

        // window = 0 behaves as 1.
        start_sweep(32'd7, 32'd1, 2'd0, 8'd1, 32'd0);
        watch(40, hi, first, dn, dcyc);
        check("w0_ring_cycles", 64'(hi), 64'd1);
        pop_check("w0", 32'd8, 32'd1);

        // start while busy is ignored.
        start_sweep(32'd1, 32'd1, 2'd0, 8'd1, 32'd4);
        tick(); tick(); tick();
        cfg_a = 32'd100; cfg_points = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        watch(60, hi, first, dn, dcyc);
        check("sb_done_pulses", 64'(dn), 64'd1);
        pop_check("sb", 32'd2, 32'd4);
        check("sb_single_entry", 64'(res_valid), 64'd0);

        // Abort during RUN of point 2.
        start_sweep(32'd20, 32'd0, 2'd1, 8'd3, 32'd5);
        for (int i = 0; i < 14; i++) tick();
        check("ab_in_run", 64'(ring_en), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_ring_low", 64'(ring_en), 64'd0);
        check("ab_done",     64'(done),    64'd1);
        tick();
        check("ab_idle", 64'(busy), 64'd0);
        pop_check("ab", 32'd20, 32'd5);
        check("ab_one_entry", 64'(res_valid), 64'd0);

        // Reset mid-sweep.
        start_sweep(32'd3, 32'd4, 2'd0, 8'd2, 32'd3);
        for (int i = 0; i < 11; i++) tick();
        check("mr_in_run", 64'(ring_en),   64'd1);
        check("mr_has_res", 64'(res_valid), 64'd1);
        wb_rst_n = 1'b0;
        tick();
        check("mr_a_out",   64'(a_out),     64'd0);
        check("mr_b_out",   64'(b_out),     64'd0);
        check("mr_ring_en", 64'(ring_en),   64'd0);
        check("mr_busy",    64'(busy),      64'd0);
        check("mr_valid",   64'(res_valid), 64'd0);
        check("mr_res_sum", 64'(res_sum),   64'd0);
        wb_rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
